// File: rtl/uart_tx.sv
// uart_tx: serial transmitter for an 8N1 UART frame, with optional even parity (8E1).
//   Owns its baud counter: each bit is held for DIV = (mhz*1e6)/baud clock cycles.
//   Build option: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset
//   tx_vld   in   1  one-cycle send request, tx_data valid
//   tx_data  in   8  byte to send, taken when tx_vld=1 and txrdy=1
//   tx       out  1  serial line, idle high, driven from a flop
//   txrdy    out  1  1 = idle, next tx_vld accepted
//   tx_ovr   out  1  one-cycle pulse: tx_vld while busy, byte dropped
module uart_tx #(
  parameter int unsigned baud = 115200,
  parameter int unsigned mhz  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       txrdy,
  output logic       tx_ovr
);

  localparam int unsigned DIV    = (mhz * 1000000) / baud;
  localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovr_q, ovr_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CntMax);

  // tx_d is the line value for the state being entered, so tx changes on the same
  // edge as the state and stays glitch-free from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ovr_d   = tx_vld && (state_q != StIdle);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_vld) begin
          state_d = StStart;
          shift_d = tx_data;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx     = tx_q;
  assign txrdy  = (state_q == StIdle);
  assign tx_ovr = ovr_q;

endmodule
